// File: rtl/des_decrypt.sv
// Iterative DES decryptor: one Feistel round per clock using a single round
// function and a single PC2, with C/D rotated right to walk subkeys K16..K1.

module IP (
    input  logic [64:1] data_i,
    output logic [64:1] data_o
);
    localparam int T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                              62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                              57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                              61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    always_comb begin
        data_o = '0;
        for (int i = 0; i < 64; i++) data_o[64-i] = data_i[65-T[i]];
    end
endmodule

module IP_inv (
    input  logic [64:1] data_i,
    output logic [64:1] data_o
);
    localparam int T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                              38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                              36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                              34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    always_comb begin
        data_o = '0;
        for (int i = 0; i < 64; i++) data_o[64-i] = data_i[65-T[i]];
    end
endmodule

module PC1 (
    input  logic [64:1] data_i,
    output logic [56:1] data_o
);
    // Parity bits (DES bits 8, 16, ..., 64) never appear in the table.
    localparam int T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    always_comb begin
        data_o = '0;
        for (int i = 0; i < 56; i++) data_o[56-i] = data_i[65-T[i]];
    end
endmodule

module PC2 (
    input  logic [56:1] data_i,
    output logic [48:1] data_o
);
    localparam int T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    always_comb begin
        data_o = '0;
        for (int i = 0; i < 48; i++) data_o[48-i] = data_i[57-T[i]];
    end
endmodule

module f (
    input  logic [32:1] r_i,
    input  logic [48:1] k_i,
    output logic [32:1] data_o
);
    localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // One 64-bit word per S-box row; column c is the nibble at bits [63-4c -: 4].
    localparam logic [63:0] SBOX [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    logic [48:1] x;
    logic [32:1] s;

    // E expansion: group g takes bits 4g..4g+5 of R, wrapping around 32.
    always_comb begin : roundFn
        logic [5:0] b;
        int row;
        int col;
        b = '0;
        row = 0;
        col = 0;
        x = '0;
        s = '0;
        data_o = '0;
        for (int i = 0; i < 48; i++)
            x[48-i] = r_i[33 - (((4*(i/6) + (i%6) + 31) % 32) + 1)] ^ k_i[48-i];
        for (int j = 0; j < 8; j++) begin
            b = x[48-6*j -: 6];
            row = int'({b[5], b[0]});
            col = int'(b[4:1]);
            s[32-4*j -: 4] = SBOX[4*j + row][63 - 4*col -: 4];
        end
        for (int i = 0; i < 32; i++) data_o[32-i] = s[33-P_T[i]];
    end
endmodule

module des_decrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic [64:1] in,
    input  logic [64:1] key,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [64:1] out,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:1] l_q, l_d, r_q, r_d;
    logic [28:1] c_q, c_d, d_q, d_d;
    logic [64:1] ipOut, ipInvOut;
    logic [56:1] pc1Out;
    logic [48:1] subKey;
    logic [32:1] fOut;
    logic        oneBitShift;

    IP     uIp    (.data_i(in),         .data_o(ipOut));
    PC1    uPc1   (.data_i(key),        .data_o(pc1Out));
    PC2    uPc2   (.data_i({c_q, d_q}), .data_o(subKey));
    f      uF     (.r_i(r_q), .k_i(subKey), .data_o(fOut));
    IP_inv uIpInv (.data_i({r_q, l_q}), .data_o(ipInvOut));

    // Round r undoes encryption round 17-r, whose left shift was 1 for 1, 2, 9, 16.
    assign oneBitShift = (cnt_q == 5'd1) || (cnt_q == 5'd8) ||
                         (cnt_q == 5'd15) || (cnt_q == 5'd16);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    {l_d, r_d} = ipOut;
                    {c_d, d_d} = pc1Out;
                    cnt_d      = 5'd1;
                    state_d    = ROUND;
                end
            end
            ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ fOut;
                c_d   = oneBitShift ? {c_q[1], c_q[28:2]} : {c_q[2:1], c_q[28:3]};
                d_d   = oneBitShift ? {d_q[1], d_q[28:2]} : {d_q[2:1], d_q[28:3]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd16) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_valid ? ipInvOut : '0;
endmodule

// File: tb/tb_des_decrypt.sv
// Directed bench for des_decrypt: known DES vectors, handshake timing, reset,
// backpressure, and a round trip against an independent encryptor model.

module tb_des_decrypt;
    logic        clk = 1'b0;
    logic        rst;
    logic [64:1] inBlk, keyBlk, outBlk;
    logic        inValid, inReady, outValid, outReady;
    int          testsRun = 0;
    int          failCount = 0;
    int          lat;

    always #5 clk = ~clk;

    des_decrypt dut (
        .clk(clk), .rst(rst), .in(inBlk), .key(keyBlk), .in_valid(inValid),
        .in_ready(inReady), .out(outBlk), .out_valid(outValid), .out_ready(outReady)
    );

    // Standard DES tables, entry order MSB-first, one byte each.
    localparam logic [511:0] IP_T = {
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2, 8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
        8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6, 8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9, 8'd1, 8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5, 8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};
    localparam logic [511:0] FP_T = {
        8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32, 8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
        8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30, 8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
        8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28, 8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
        8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26, 8'd33, 8'd1, 8'd41, 8'd9, 8'd49, 8'd17, 8'd57, 8'd25};
    localparam logic [447:0] PC1_T = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9, 8'd1, 8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2, 8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3, 8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7, 8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6, 8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5, 8'd28, 8'd20, 8'd12, 8'd4};
    localparam logic [383:0] PC2_T = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1, 8'd5, 8'd3, 8'd28, 8'd15, 8'd6, 8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4, 8'd26, 8'd8, 8'd16, 8'd7, 8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32};
    localparam logic [383:0] E_T = {
        8'd32, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
        8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
        8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
        8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1};
    localparam logic [255:0] P_T = {
        8'd16, 8'd7, 8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17, 8'd1, 8'd15, 8'd23, 8'd26, 8'd5, 8'd18, 8'd31, 8'd10,
        8'd2, 8'd8, 8'd24, 8'd14, 8'd32, 8'd27, 8'd3, 8'd9, 8'd19, 8'd13, 8'd30, 8'd6, 8'd22, 8'd11, 8'd4, 8'd25};
    localparam logic [63:0] SB [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    // Generic DES permutation: DES bit n of an inW-bit word lives at index inW-n.
    function automatic logic [63:0] perm(input logic [63:0] x, input int inW, input int outW,
                                         input logic [511:0] t);
        logic [63:0] y = '0;
        for (int i = 0; i < outW; i++) begin
            int src = int'(t[8*(outW-i)-1 -: 8]);
            y[outW-1-i] = x[inW - src];
        end
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] tmp;
        logic [63:0] w;
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b;
        tmp = perm({32'd0, r}, 32, 48, 512'(E_T));
        x = tmp[47:0] ^ k;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            b = x[47-6*j -: 6];
            w = SB[4*j + int'({b[5], b[0]})];
            s[31-4*j -: 4] = w[63 - 4*int'(b[4:1]) -: 4];
        end
        tmp = perm({32'd0, s}, 32, 32, 512'(P_T));
        return tmp[31:0];
    endfunction

    // Forward DES, left-rotating the key halves as the standard describes.
    function automatic logic [63:0] desEncrypt(input logic [63:0] p, input logic [63:0] k);
        logic [63:0] tmp;
        logic [27:0] c, d;
        logic [31:0] l, r, t;
        logic [47:0] sk;
        int          sh;
        tmp = perm(k, 64, 56, 512'(PC1_T));
        c = tmp[55:28];
        d = tmp[27:0];
        tmp = perm(p, 64, 64, IP_T);
        l = tmp[63:32];
        r = tmp[31:0];
        for (int rnd = 1; rnd <= 16; rnd++) begin
            sh = (rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16) ? 1 : 2;
            c = (c << sh) | (c >> (28 - sh));
            d = (d << sh) | (d >> (28 - sh));
            tmp = perm({8'd0, c, d}, 56, 48, 512'(PC2_T));
            sk = tmp[47:0];
            t = r;
            r = l ^ feistel(r, sk);
            l = t;
        end
        return perm({r, l}, 64, 64, FP_T);
    endfunction

    task automatic applyStimulus(input logic [63:0] c, input logic [63:0] k, input logic v);
        inBlk   = c;
        keyBlk  = k;
        inValid = v;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitValid(output int n);
        n = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (outValid === 1'b1) begin
                n = e;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        outReady = 1'b0;
        applyStimulus('0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out", outBlk, 64'd0);
        checkOutput("reset flags", 64'({inReady, outValid}), 64'b10);

        // Basic vector, accepted on the first edge after reset release.
        rst = 1'b0;
        outReady = 1'b1;
        applyStimulus(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1);
        @(posedge clk); #1;
        checkOutput("v1 accepted", 64'(inReady), 64'd0);
        applyStimulus('0, '0, 1'b0);
        waitValid(lat);
        checkOutput("v1 latency", 64'(lat), 64'd16);
        checkOutput("v1 plaintext", outBlk, 64'h0123456789ABCDEF);
        @(posedge clk); #1;
        checkOutput("v1 one-cycle flags", 64'({inReady, outValid}), 64'b10);
        checkOutput("v1 out cleared", outBlk, 64'd0);

        // Back-to-back with in_valid held high.
        applyStimulus(64'h0, 64'h0E329232EA6D0D73, 1'b1);
        @(posedge clk); #1;
        checkOutput("v2 accepted", 64'(inReady), 64'd0);
        waitValid(lat);
        checkOutput("v2 latency", 64'(lat), 64'd16);
        checkOutput("v2 plaintext", outBlk, 64'h8787878787878787);
        @(posedge clk); #1;
        checkOutput("v2 no bypass on drain", 64'({inReady, outValid}), 64'b10);
        @(posedge clk); #1;
        checkOutput("v2 re-accept after drain", 64'({inReady, outValid}), 64'b00);
        waitValid(lat);
        checkOutput("v2b latency", 64'(lat), 64'd16);
        checkOutput("v2b plaintext", outBlk, 64'h8787878787878787);
        applyStimulus('0, '0, 1'b0);
        @(posedge clk); #1;
        checkOutput("v2b drain", 64'({inReady, outValid}), 64'b10);

        // Inputs altered while busy, then backpressure with an ignored pulse.
        outReady = 1'b0;
        applyStimulus(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1);
        @(posedge clk); #1;
        applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 1'b1);
        waitValid(lat);
        checkOutput("busy latency", 64'(lat), 64'd16);
        checkOutput("busy input change", outBlk, 64'h0123456789ABCDEF);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, i == 2);
            @(posedge clk); #1;
            checkOutput("bp out stable", outBlk, 64'h0123456789ABCDEF);
            checkOutput("bp flags", 64'({inReady, outValid}), 64'b01);
        end
        applyStimulus('0, '0, 1'b0);
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp release", 64'({inReady, outValid}), 64'b10);
        @(posedge clk); #1;
        checkOutput("bp pulse not queued", 64'({inReady, outValid}), 64'b10);

        // Reset after round 8 discards the block.
        applyStimulus(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1);
        @(posedge clk); #1;
        applyStimulus('0, '0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset out", outBlk, 64'd0);
        checkOutput("midreset flags", 64'({inReady, outValid}), 64'b10);
        @(posedge clk); #1;
        applyStimulus(64'h0, 64'h0E329232EA6D0D73, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post-reset accept", 64'({inReady, outValid}), 64'b00);
        applyStimulus('0, '0, 1'b0);
        waitValid(lat);
        checkOutput("post-reset latency", 64'(lat), 64'd16);
        checkOutput("post-reset plaintext", outBlk, 64'h8787878787878787);
        @(posedge clk); #1;

        // Round trip through the encryptor model with per-cycle handshake checks.
        for (int n = 0; n < 1000; n++) begin
            logic [63:0] p, k, c;
            int stall;
            p = {$urandom, $urandom};
            k = {$urandom, $urandom};
            c = desEncrypt(p, k);
            stall = $urandom_range(0, 2);
            outReady = 1'b0;
            applyStimulus(c, k, 1'b1);
            checkOutput("rt idle", 64'({inReady, outValid}), 64'b10);
            @(posedge clk); #1;
            applyStimulus(~c, ~k, 1'b0);
            for (int i = 1; i <= 16; i++) begin
                @(posedge clk); #1;
                checkOutput("rt handshake", 64'({inReady, outValid}), (i == 16) ? 64'b01 : 64'b00);
            end
            checkOutput("rt plaintext", outBlk, p);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                checkOutput("rt stall hold", outBlk, p);
            end
            outReady = 1'b1;
            @(posedge clk); #1;
            checkOutput("rt drain", 64'({inReady, outValid}), 64'b10);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/des_decrypt.md
DES_DECRYPT -- requirements
Module: des_decrypt

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in  input  [64:1]  ciphertext block; bit 64 = DES bit 1 (MSB-first numbering, as in the encryptor).
REQ-005 key  input  [64:1]  64-bit DES key including parity bits; parity SHALL be ignored by PC1.
REQ-006 in_valid  input  1  ciphertext/key pair presented.
REQ-007 in_ready  output  1  block can accept a new pair.
REQ-008 out  output  [64:1]  recovered plaintext, same bit numbering as in.
REQ-009 out_valid  output  1  out holds a valid plaintext.
REQ-010 out_ready  input  1  consumer accepts out.

Function
REQ-011 The block SHALL be iterative: one Feistel round per clock, reusing the existing IP, IP_inv, PC1, PC2 and f modules (one f instance, one PC2 instance).
REQ-012 FSM states SHALL be IDLE, ROUND, DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-013 Accept SHALL occur on an edge where state=IDLE and in_valid=1: {L,R} <= IP(in); {C,D} <= PC1(key); round counter <= 1; state <= ROUND.
REQ-014 in and key SHALL be sampled only on the accept edge; changes at any other time SHALL have no effect.
REQ-015 In ROUND, each edge SHALL perform the following: K = PC2({C,D}); L <= R; R <= L ^ f(R,K); counter <= counter+1.
REQ-016 Decryption round r (1..16) SHALL use encryption subkey K(17-r); the first round uses K16 = PC2(PC1(key)), since C16=C0 and D16=D0.
REQ-017 After round r, C and D SHALL each rotate RIGHT by the encryption shift of round 17-r: 1 bit when 17-r is in {1,2,9,16}, otherwise 2 bits; total rotation over 16 rounds SHALL be 28 bits.
REQ-018 The counter SHALL be 5 bits wide; on the edge completing round 16 the state SHALL become DONE and the counter SHALL NOT wrap into a 17th round.
REQ-019 out SHALL equal IP_inv({R16, L16}) (swapped halves) while out_valid=1, and SHALL be 0 otherwise.
REQ-020 Latency: out_valid SHALL rise exactly 16 clk edges after the accept edge.
REQ-021 In DONE, out and out_valid SHALL be held stable until an edge with out_ready=1, after which state SHALL become IDLE (out_valid=0, in_ready=1 on the following cycle).
REQ-022 No bypass: a new pair SHALL NOT be accepted on the same edge that drains DONE; minimum spacing SHALL be 18 cycles between accepts.
REQ-023 in_valid asserted in ROUND or DONE SHALL be ignored, with no queuing.
REQ-024 The operation SHALL be the exact inverse of the existing combinational encryptor: for all in and key, des_decrypt(main(p,key),key) = p.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force state=IDLE, counter=0, L=R=C=D=0, out_valid=0, out=0 and in_ready=1.
REQ-026 Reset asserted mid-operation (any round or DONE) SHALL discard the block in progress with no partial output.
REQ-027 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-028 Basic vector: key=133457799BBCDFF1, in=85E813540F0AB405, out_ready=1 -> out=0123456789ABCDEF with out_valid high exactly 16 edges after accept, for 1 cycle.
REQ-029 Second vector back-to-back: key=0E329232EA6D0D73, in=0000000000000000, with in_valid held high continuously -> out=8787878787878787; the next accept occurs no earlier than the cycle after the drain.
REQ-030 Backpressure: out_ready=0 for 5 cycles after out_valid -> out stays stable, in_ready=0, and a new in_valid pulse during this time is ignored; release -> IDLE.
REQ-031 Reset mid-round: assert rst after round 8 -> out_valid=0, out=0, in_ready=1 immediately; no stale output after rst deasserts.
REQ-032 Input change while busy: alter in and key during ROUND -> result still matches the originally accepted pair.
REQ-033 Round-trip: 1000 random (p,key) pairs through main then des_decrypt -> out=p for every pair, and the bench checks in_valid/in_ready and out_valid/out_ready handshakes on every cycle.
